weight_preload_shifter: RTL
===========================

Name: weight_preload_shifter

Overview:
- Sits directly downstream of the weight fill controller, between it and the systolic PE array.
- Captures the flattened weight image (array_size rows × array_size words) when the fill controller signals done.
- Streams the image into the array's weight shift chain one row per accepted cycle, under array back-pressure.
- Signals completion so the array controller can start the compute phase.

Parameters:
- data_size, 16, bits per weight word.
- array_size, 9, PE array dimension; the image holds array_size×array_size words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fill_done  input  1  level "done" from the weight fill controller; stays high once filling finishes.
- weight_in  input  data_size*array_size*array_size  flattened weight image. Row r occupies bits [(r+1)*array_size*data_size-1 : r*array_size*data_size]. Word c of a row occupies [(c+1)*data_size-1 : c*data_size] within that row.
- array_ready  input  1  PE array can accept a weight row this cycle.
- weight_row  output  data_size*array_size  row presented to the array's weight chain.
- weight_shift  output  1  row on weight_row is transferred this cycle.
- busy  output  1  high from capture until preload_done.
- preload_done  output  1  one-cycle pulse after the last row is transferred.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. weight_row=0, weight_shift=0, busy=0, preload_done=0. Row counter=0, image register=0, fill_done edge register=0. Reset mid-stream aborts immediately; no partial-done pulse is produced.
- Edge detect: fill_done is registered each cycle. A start event is fill_done=1 while the registered value is 0. Start events outside IDLE are ignored. Re-arming requires fill_done to drop and rise again.
- States: IDLE, CAPTURE, SHIFT, DONE.
- IDLE: outputs low. A start event moves to CAPTURE.
- CAPTURE (1 cycle): latch weight_in into the image register, clear the row counter, set busy=1, go to SHIFT. weight_in is not sampled after this cycle.
- SHIFT, per cycle:
  - weight_row is driven combinationally from the image register: row (array_size-1-count), i.e. the last row first, so row 0 lands in the first PE row.
  - weight_shift = array_ready.
  - If array_ready=1: count increments. When count reaches array_size-1 on an accepted cycle, go to DONE.
  - If array_ready=0: count and weight_row hold; weight_shift=0.
- DONE (1 cycle): preload_done=1, busy=0, weight_row=0, then return to IDLE.
- Latency: the start event is sampled at edge N. CAPTURE occupies N+1. The first possible shift is N+2. With array_ready held high, the last shift is at N+1+array_size and preload_done at N+2+array_size.
- weight_shift is high for exactly array_size cycles per preload, never in IDLE, CAPTURE or DONE.
- Counter width is clog2(array_size) bits, minimum 1. No wrap: the counter is cleared in CAPTURE and stops at array_size-1.
- weight_row is 0 whenever the state is not SHIFT.

Optional Feature:
- Macro: WEIGHT_TRANSPOSE_EN.
- Defined: in SHIFT the emitted vector is column (array_size-1-count) of the image instead of the row. Word c of weight_row is image word [row c][column array_size-1-count]. This supports arrays with a column-oriented weight chain. Timing, handshake and counts are unchanged.
- Undefined: row emission as specified above; no transpose logic is synthesized.

Test Plan (array_size=3, data_size=8, word[r][c]=16*r+c):
- Basic: fill_done rises at edge 5, array_ready=1 -> weight_shift high on edges 7,8,9 with weight_row words {0x20,0x21,0x22}, {0x10,0x11,0x12}, {0x00,0x01,0x02}; preload_done pulses at edge 10; busy high on edges 6-9.
- Back-pressure: array_ready=0 on the second SHIFT cycle -> weight_row holds {0x10,0x11,0x12} with weight_shift=0. Exactly 3 shifts total; preload_done is delayed by one cycle, at edge 11.
- Level/re-arm: fill_done held high for 20 cycles -> exactly one preload. Drop fill_done, raise again -> a second preload with the identical row sequence.
- Capture isolation: change weight_in to all 0xFF after CAPTURE -> emitted rows still match the captured image.
- Reset mid-stream: assert reset after the first shift -> all outputs 0 immediately, no preload_done pulse. A new fill_done rising edge after release -> a full 3-row preload.
- WEIGHT_TRANSPOSE_EN defined -> first emitted vector has words {0x02,0x12,0x22}, then {0x01,0x11,0x21}, then {0x00,0x10,0x20}.

Source files
------------

// File: rtl/weight_preload_shifter.sv
// Captures a flattened weight image on a fill_done rising edge and streams it into the PE array's weight chain, last row first.
// Define WEIGHT_TRANSPOSE_EN to emit image columns instead of rows.
module weight_preload_shifter #(
  parameter int unsigned data_size  = 16,
  parameter int unsigned array_size = 9
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          fill_done,
  input  logic [data_size*array_size*array_size-1:0]    weight_in,
  input  logic                                          array_ready,
  output logic [data_size*array_size-1:0]               weight_row,
  output logic                                          weight_shift,
  output logic                                          busy,
  output logic                                          preload_done
);

  localparam int unsigned RowW = data_size * array_size;
  localparam int unsigned ImgW = RowW * array_size;
  localparam int unsigned CntW = (array_size > 1) ? $clog2(array_size) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(array_size - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ImgW-1:0]     img_q, img_d;
  logic                fill_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_c;
  logic [RowW-1:0]     vec_sel_c;

  assign start_c = fill_done & ~fill_q;

`ifdef WEIGHT_TRANSPOSE_EN
  // Column (array_size-1-count): word c comes from row c of the image.
  always_comb begin
    vec_sel_c = '0;
    for (int unsigned k = 0; k < array_size; k++) begin
      if (CntW'(array_size - 1 - k) == cnt_q) begin
        for (int unsigned c = 0; c < array_size; c++) begin
          vec_sel_c[c*data_size +: data_size] = img_q[c*RowW + k*data_size +: data_size];
        end
      end
    end
  end
`else
  // Row (array_size-1-count), so row 0 ends up in the first PE row.
  always_comb begin
    vec_sel_c = '0;
    for (int unsigned r = 0; r < array_size; r++) begin
      if (CntW'(array_size - 1 - r) == cnt_q) begin
        vec_sel_c = img_q[r*RowW +: RowW];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      img_q   <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      fill_q  <= fill_done;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    img_d        = img_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    weight_row   = '0;
    weight_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = CAPTURE;
          busy_d  = 1'b1;
        end
      end
      CAPTURE: begin
        img_d   = weight_in;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy_d       = 1'b1;
        weight_row   = vec_sel_c;
        weight_shift = array_ready;
        if (array_ready) begin
          if (cnt_q == CntLast) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy         = busy_q;
  assign preload_done = done_q;

endmodule
